// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline register chain and forwarding unit:
// bubble instruction, opcode/funct constants and the stage-action encoding.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_REG  = 6'b000000;
  localparam logic [5:0] OP_JUMP = 6'b000010;
  localparam logic [5:0] OP_BGTI = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_SLLI = 6'b011000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_NOP  = 6'b000000;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ACT_RUN        = 2'd0,
    ACT_STALL_IDEX = 2'd1,
    ACT_STALL_IFID = 2'd2,
    ACT_FLUSH      = 2'd3
  } stage_action_e;

  // Load-use stall outranks the jump stall, which outranks the flush.
  function automatic stage_action_e select_action(input logic stall_idex,
                                                  input logic stall_ifid,
                                                  input logic flush_ifid);
    stage_action_e act;
    if (stall_idex) begin
      act = ACT_STALL_IDEX;
    end else if (stall_ifid) begin
      act = ACT_STALL_IFID;
    end else if (flush_ifid) begin
      act = ACT_FLUSH;
    end else begin
      act = ACT_RUN;
    end
    return act;
  endfunction

endpackage

// File: rtl/pipe_stage_regs_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_C = {W{1'b1}};
  localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;
  logic [W-1:0] count_nxt_s;

  // Next count: increment unless already at the ceiling.
  always_comb begin
    count_nxt_s = count_r;
    if (inc && (count_r != MAX_C)) begin
      count_nxt_s = count_r + ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_r <= {W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_stage_regs.sv
// IF/ID -> ID/EX -> EX/MEM -> MEM/WB instruction and data registers with
// stall/bubble/flush control and saturating stall/flush event counters.
module pipe_stage_regs
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_if,
  input  logic [31:0]      alu_result_ex,
  input  logic [31:0]      store_data_ex,
  input  logic [31:0]      mem_rdata,
  input  logic             stall_ifid,
  input  logic             stall_idex,
  input  logic             flush_ifid,
  output logic             pc_en,
  output logic [31:0]      instrIFID,
  output logic [31:0]      instrIDEX,
  output logic [31:0]      instrEXMEM,
  output logic [31:0]      instrMEMWB,
  output logic [31:0]      aluEXMEM_Data,
  output logic [31:0]      aluMEMWB_Data,
  output logic [31:0]      EXMEM_Data2Mem,
  output logic [31:0]      MEMWB_MemData,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_action_e action_s;

  logic [31:0] ifid_r, idex_r, exmem_r, memwb_r;
  logic [31:0] alu_exmem_r, alu_memwb_r, st_exmem_r, ld_memwb_r;

  logic [31:0] ifid_nxt_s, idex_nxt_s, exmem_nxt_s;
  logic [31:0] alu_exmem_nxt_s, st_exmem_nxt_s;

  logic stall_any_s;
  logic flush_applied_s;

  // Decode the prioritised stage action for this cycle.
  always_comb begin
    action_s = select_action(stall_idex, stall_ifid, flush_ifid);
  end

  assign stall_any_s     = stall_ifid | stall_idex;
  assign flush_applied_s = (action_s == ACT_FLUSH);
  assign pc_en           = ~stall_any_s;

  // Next-state of the front stages (IF/ID, ID/EX) per stage action.
  always_comb begin
    ifid_nxt_s = ifid_r;
    idex_nxt_s = idex_r;
    case (action_s)
      ACT_RUN: begin
        ifid_nxt_s = instr_if;
        idex_nxt_s = ifid_r;
      end
      ACT_STALL_IDEX: begin
        ifid_nxt_s = ifid_r;
        idex_nxt_s = idex_r;
      end
      ACT_STALL_IFID: begin
        ifid_nxt_s = ifid_r;
        idex_nxt_s = NOP_INSTR;
      end
      ACT_FLUSH: begin
        ifid_nxt_s = NOP_INSTR;
        idex_nxt_s = ifid_r;
      end
      default: begin
        ifid_nxt_s = NOP_INSTR;
        idex_nxt_s = NOP_INSTR;
      end
    endcase
  end

  // Next-state of EX/MEM: a load-use stall injects a bubble with zeroed data.
  always_comb begin
    exmem_nxt_s     = idex_r;
    alu_exmem_nxt_s = alu_result_ex;
    st_exmem_nxt_s  = store_data_ex;
    if (action_s == ACT_STALL_IDEX) begin
      exmem_nxt_s     = NOP_INSTR;
      alu_exmem_nxt_s = 32'h0000_0000;
      st_exmem_nxt_s  = 32'h0000_0000;
    end else begin
      exmem_nxt_s     = idex_r;
      alu_exmem_nxt_s = alu_result_ex;
      st_exmem_nxt_s  = store_data_ex;
    end
  end

  // Stage registers; MEM/WB advances under every action.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_r      <= NOP_INSTR;
      idex_r      <= NOP_INSTR;
      exmem_r     <= NOP_INSTR;
      memwb_r     <= NOP_INSTR;
      alu_exmem_r <= 32'h0000_0000;
      st_exmem_r  <= 32'h0000_0000;
      alu_memwb_r <= 32'h0000_0000;
      ld_memwb_r  <= 32'h0000_0000;
    end else begin
      ifid_r      <= ifid_nxt_s;
      idex_r      <= idex_nxt_s;
      exmem_r     <= exmem_nxt_s;
      alu_exmem_r <= alu_exmem_nxt_s;
      st_exmem_r  <= st_exmem_nxt_s;
      memwb_r     <= exmem_r;
      alu_memwb_r <= alu_exmem_r;
      ld_memwb_r  <= mem_rdata;
    end
  end

  assign instrIFID      = ifid_r;
  assign instrIDEX      = idex_r;
  assign instrEXMEM     = exmem_r;
  assign instrMEMWB     = memwb_r;
  assign aluEXMEM_Data  = alu_exmem_r;
  assign EXMEM_Data2Mem = st_exmem_r;
  assign aluMEMWB_Data  = alu_memwb_r;
  assign MEMWB_MemData  = ld_memwb_r;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_any_s),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (flush_applied_s),
    .count (flush_cnt)
  );

endmodule

// File: doc/pipe_stage_regs.md
# pipe_stage_regs

Instruction/data pipeline register chain for the 5-stage MIPS core. It is the producer side of the `dataForwarding` interface:
- supplies `instrIFID`, `instrIDEX`, `instrEXMEM`, `instrMEMWB` and the EX/MEM and MEM/WB data words that the forwarding unit inspects;
- consumes the forwarding unit's `stall_ifid`, `stall_idex` and `flush_ifid` to hold stages, insert bubbles and squash fetched instructions;
- keeps saturating stall/flush event counters for performance debug.

## Interface
- `NOP_INSTR`, 32'h0000_0000, bubble instruction (`sll $0,$0,0`, funct NOP).
- `CNT_W`, 16, width of each event counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `instr_if`  in  32  instruction fetched this cycle.
- `alu_result_ex`  in  32  ALU result produced in EX.
- `store_data_ex`  in  32  forwarded rt value leaving EX, destined for data memory.
- `mem_rdata`  in  32  data-memory read data for the instruction in EX/MEM.
- `stall_ifid`  in  1  hold IF/ID and insert a bubble into ID/EX (jump operand not ready).
- `stall_idex`  in  1  load-use hazard: hold IF/ID and ID/EX, and insert a bubble into EX/MEM.
- `flush_ifid`  in  1  squash the IF/ID instruction (taken jump/branch).
- `pc_en`  out  1  PC update enable.
- `instrIFID`, `instrIDEX`, `instrEXMEM`, `instrMEMWB`  out  32 each  stage instruction registers.
- `aluEXMEM_Data`, `aluMEMWB_Data`  out  32 each  ALU result at MEM and at WB.
- `EXMEM_Data2Mem`  out  32  store data at MEM.
- `MEMWB_MemData`  out  32  load data at WB.
- `stall_cnt`  out  CNT_W  cycles with any stall asserted (saturating).
- `flush_cnt`  out  CNT_W  applied flushes (saturating).

## Operation
- Reset:
  - all instruction registers = NOP_INSTR;
  - all data registers and counters = 0;
  - `pc_en` = 1.
- Stage action is selected by `stall_idex`, then `stall_ifid`, then `flush_ifid`, in strict priority order:
  - **RUN** (none asserted): IF/ID←`instr_if`; ID/EX←IF/ID; EX/MEM←ID/EX, `aluEXMEM_Data`←`alu_result_ex`, `EXMEM_Data2Mem`←`store_data_ex`; MEM/WB←EX/MEM, `aluMEMWB_Data`←`aluEXMEM_Data`, `MEMWB_MemData`←`mem_rdata`.
  - **STALL_IDEX**: IF/ID and ID/EX hold. EX/MEM←NOP_INSTR with its data words ←0. MEM/WB advances normally. `flush_ifid` is ignored this cycle; the forwarding unit re-asserts it after the stall clears.
  - **STALL_IFID**: IF/ID holds. ID/EX←NOP_INSTR. EX/MEM and MEM/WB advance. A simultaneous `flush_ifid` is ignored.
  - **FLUSH**: IF/ID←NOP_INSTR (the fetched `instr_if` is discarded). All later stages advance.
- `pc_en` = ~(`stall_ifid` | `stall_idex`). This is the only combinational output.
- Counters:
  - `stall_cnt` increments on every cycle with either stall input asserted.
  - `flush_cnt` increments only in FLUSH.
  - Both stop at 2^CNT_W−1; no wrap-around.
- Data words have no width conversion; they are copied as-is.

## Timing
- Every output except `pc_en` is registered and updates on the rising edge.
- Latency is one cycle per stage: an instruction presented on `instr_if` at edge N appears at `instrIFID` after N, `instrIDEX` after N+1, `instrEXMEM` after N+2, `instrMEMWB` after N+3, assuming no stalls.
- Each stall cycle adds exactly one cycle of latency for every instruction at or before the held stage. Back-to-back stalls hold indefinitely with no loss.
- `rst` dominates all other inputs. Reset asserted mid-stall clears every stage to NOP_INSTR on the same edge, and the next cycle is RUN.
- Stall and flush inputs are sampled every edge. They are level, not pulse, semantics.

## Structure
- Shared package `pipe_pkg` holds: NOP_INSTR; opcode constants (REG, JUMP, BGTI, ADDI, SLTI, ANDI, ORI, XORI, SLLI, LW, SW); funct constants (NOP, SLLV, JR, ADD, SUB, AND, OR, XOR, SLT); and the stage-action encoding RUN/STALL_IDEX/STALL_IFID/FLUSH. The forwarding unit uses the same package.
- One sub-module: `sat_counter` (parameterised width, synchronous clear, saturating increment), instantiated twice.

## Test plan
- **Reset**: hold `rst` 2 cycles with `instr_if`=32'h2008_0005 → all four instr outputs = 0, counters = 0, `pc_en`=1.
- **Plain flow**: feed ADDI 32'h2008_0005 then 32'h2009_0007 with `alu_result_ex`=2 and `mem_rdata`=8 → the first instruction reaches `instrMEMWB` 4 edges after it is presented; `aluMEMWB_Data`=2 and `MEMWB_MemData`=8 one stage after EX/MEM.
- **Load-use**: LW in ID/EX, assert `stall_idex` for 1 cycle → `pc_en`=0 during the stall; `instrIFID`/`instrIDEX` unchanged; `instrEXMEM`=0 next cycle; `stall_cnt`=1.
- **Jump stall**: BGTI in IF/ID, assert `stall_ifid` 2 cycles → `instrIDEX`=0 for 2 cycles, BGTI held in IF/ID, `stall_cnt`=2.
- **Flush and priority**: assert `flush_ifid` alone → `instrIFID`=0, `flush_cnt`=1. Then assert `flush_ifid` together with `stall_idex` → IF/ID held (not 0), `flush_cnt` stays 1.
- **Saturation and mid-stall reset**: run with CNT_W=2 and 5 stall cycles → `stall_cnt`=3. Then assert `rst` during a stall → every stage = 0 on the next edge.
